// File: rtl/ws2812_rx_if.sv
// WS2812 receive bundle: the serial line in, decoded pixel words and frame status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; pixel_valid and frame_end are single-cycle strobes that cannot be stalled.
//
// master: decoder side (samples din, drives results). slave: consumer side.
interface ws2812_rx_if #(
  parameter int MAX_PIXELS = 8
) ();
  localparam int CNT_W = $clog2(MAX_PIXELS + 1);

  logic             din;
  logic [23:0]      pixel;
  logic             pixel_valid;
  logic [CNT_W-1:0] pixel_cnt;
  logic             frame_end;
  logic             error;

  modport master (
    input  din,
    output pixel, pixel_valid, pixel_cnt, frame_end, error
  );

  modport slave (
    output din,
    input  pixel, pixel_valid, pixel_cnt, frame_end, error
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 NRZ decoder: measures high-pulse widths, assembles 24-bit pixels MSB first, detects the latch gap.
// Latency: din falling edge to pixel_valid is 4 clk (2 sync, 1 edge register, 1 output register).
// Backpressure: none; results are strobes and the consumer must take them in the cycle they appear.
//
// Ports: clk, reset (synchronous, active-high), bus (ws2812_rx_if.master):
//   din in; pixel[23:0], pixel_valid, pixel_cnt, frame_end, error (sticky) out.
module ws2812_rx #(
  parameter int CLK_SPEED  = 25_000_000,
  parameter int MAX_PIXELS = 8
) (
  input  logic         clk,
  input  logic         reset,
  ws2812_rx_if.master  bus
);
  localparam int CNT_W   = $clog2(MAX_PIXELS + 1);
  localparam int T_MIN   = CLK_SPEED / 6_000_000;
  localparam int T_TH    = CLK_SPEED * 6 / 10_000_000;
  localparam int T_MAX   = CLK_SPEED / 500_000;
  localparam int T_LATCH = CLK_SPEED / 20_000;
  localparam int W       = $clog2(T_LATCH + 1);

  localparam logic [W:0]       LIM_MIN   = T_MIN[W:0];
  localparam logic [W:0]       LIM_TH    = T_TH[W:0];
  localparam logic [W:0]       LIM_MAX   = T_MAX[W:0];
  localparam logic [W:0]       LIM_LATCH = T_LATCH[W:0];
  localparam logic [W-1:0]     SAT_LATCH = T_LATCH[W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX   = MAX_PIXELS[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

  state_t           state;
  logic             s1, s2, s2_d;
  logic             rise_q, fall_q;
  logic [W-1:0]     width;
  logic [4:0]       bit_cnt;
  logic [22:0]      shift;
  logic [23:0]      pixel_q;
  logic             pixel_valid_q;
  logic [CNT_W-1:0] pixel_cnt_q;
  logic             frame_end_q;
  logic             error_q;

  // meas includes the current cycle, so on the cycle a falling edge is
  // handled it equals the number of cycles din was high.
  logic [W:0]   meas;
  logic [W-1:0] width_inc;
  logic         new_bit;

  always_comb begin
    meas      = {1'b0, width} + {{W{1'b0}}, 1'b1};
    width_inc = (meas >= LIM_LATCH) ? SAT_LATCH : meas[W-1:0];
    new_bit   = (meas >= LIM_TH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      s1            <= 1'b0;
      s2            <= 1'b0;
      s2_d          <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      width         <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_cnt_q   <= '0;
      frame_end_q   <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      s1     <= bus.din;
      s2     <= s1;
      s2_d   <= s2;
      // Registered edge flags; s2_d holds the line level matching them.
      rise_q <= s2 & ~s2_d;
      fall_q <= ~s2 & s2_d;

      pixel_valid_q <= 1'b0;
      frame_end_q   <= 1'b0;

      // Cycle after frame_end: start a fresh count. Any error raised
      // below in this same cycle overrides the clear.
      if (frame_end_q) begin
        pixel_cnt_q <= '0;
        error_q     <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rise_q) begin
            state <= HIGH;
            width <= '0;
          end
        end

        HIGH: begin
          if (meas >= LIM_MAX) begin
            error_q <= 1'b1;
            state   <= ERR;
            width   <= '0;
          end else if (fall_q) begin
            width <= '0;
            if (meas < LIM_MIN) begin
              error_q <= 1'b1;
              state   <= ERR;
            end else begin
              state <= LOW;
              shift <= {shift[21:0], new_bit};
              if (bit_cnt == 5'd23) begin
                pixel_q       <= {shift, new_bit};
                pixel_valid_q <= 1'b1;
                bit_cnt       <= '0;
                if (pixel_cnt_q < CNT_MAX) pixel_cnt_q <= pixel_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else begin
            width <= width_inc;
          end
        end

        LOW: begin
          if (meas >= LIM_LATCH) begin
            frame_end_q <= 1'b1;
            if (bit_cnt != 5'd0) error_q <= 1'b1;  // partial pixel dropped
            bit_cnt <= '0;
            shift   <= '0;
            width   <= '0;
            state   <= rise_q ? HIGH : IDLE;
          end else if (rise_q) begin
            state <= HIGH;
            width <= '0;
          end else begin
            width <= width_inc;
          end
        end

        ERR: begin
          // Edges are ignored; only an unbroken low of T_LATCH recovers.
          if (s2_d) begin
            width <= '0;
          end else if (meas >= LIM_LATCH) begin
            frame_end_q <= 1'b1;
            bit_cnt     <= '0;
            shift       <= '0;
            width       <= '0;
            state       <= IDLE;
          end else begin
            width <= width_inc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_cnt   = pixel_cnt_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.error       = error_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: two decoders (MAX_PIXELS 8 and 2) share one serial line.
// Stimulus pushes expected pixels and frame-end status into queues; monitors pop and compare.
module tb_ws2812_rx;
  logic clk = 1'b0;
  logic reset;
  logic din;

  always #5 clk = ~clk;

  ws2812_rx_if #(.MAX_PIXELS(8)) bus_a ();
  ws2812_rx_if #(.MAX_PIXELS(2)) bus_b ();
  assign bus_a.din = din;
  assign bus_b.din = din;

  ws2812_rx #(.CLK_SPEED(25_000_000), .MAX_PIXELS(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  ws2812_rx #(.CLK_SPEED(25_000_000), .MAX_PIXELS(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct { logic [23:0] px; int cnt; } pix_exp_t;
  typedef struct { int err; int cnt; int lat; } fe_exp_t;

  pix_exp_t qa[$];
  pix_exp_t qb[$];
  fe_exp_t  qf[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_frame = 0;
  int last_pv_cyc = 0;
  bit fe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    pix_exp_t e;
    fe_exp_t  f;
    if (!reset) begin
      if (fe_prev) begin
        check("cnt_after_frame_end", int'(bus_a.pixel_cnt), 0);
        check("error_after_frame_end", int'(bus_a.error), 0);
      end
      fe_prev = bus_a.frame_end;
      if (bus_a.pixel_valid) begin
        last_pv_cyc = cyc;
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pixel_a: got 0x%0h with no pixel expected", bus_a.pixel);
        end else begin
          e = qa.pop_front();
          check("pixel_a", int'(bus_a.pixel), int'(e.px));
          check("pixel_cnt_a", int'(bus_a.pixel_cnt), e.cnt);
        end
      end
      if (bus_a.frame_end) begin
        if (qf.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame_end: frame_end seen with none expected");
        end else begin
          f = qf.pop_front();
          check("frame_end_error", int'(bus_a.error), f.err);
          check("frame_end_cnt", int'(bus_a.pixel_cnt), f.cnt);
          if (f.lat != 0) check("frame_end_latency", cyc - last_pv_cyc, 1250);
        end
      end
    end
  end

  always @(negedge clk) begin
    pix_exp_t e;
    if (!reset && bus_b.pixel_valid) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pixel_b: got 0x%0h with no pixel expected", bus_b.pixel);
      end else begin
        e = qb.pop_front();
        check("pixel_b", int'(bus_b.pixel), int'(e.px));
        check("pixel_cnt_b", int'(bus_b.pixel_cnt), e.cnt);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(20, 11);
    else   pulse(10, 21);
  endtask

  task automatic send_bits(input logic [23:0] w, input int hi_idx, input int lo_idx);
    for (int i = hi_idx; i >= lo_idx; i--) send_bit(w[i]);
  endtask

  task automatic expect_pixel(input logic [23:0] px);
    n_frame++;
    qa.push_back('{px, (n_frame > 8) ? 8 : n_frame});
    qb.push_back('{px, (n_frame > 2) ? 2 : n_frame});
  endtask

  task automatic send_pixel(input logic [23:0] px);
    expect_pixel(px);
    send_bits(px, 23, 0);
  endtask

  task automatic latch(input int err, input int lat);
    qf.push_back('{err, (n_frame > 8) ? 8 : n_frame, lat});
    din = 1'b0;
    repeat (1300) @(negedge clk);
    n_frame = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    din   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_pixel", int'(bus_a.pixel), 0);
    check("reset_pixel_valid", int'(bus_a.pixel_valid), 0);
    check("reset_pixel_cnt", int'(bus_a.pixel_cnt), 0);
    check("reset_frame_end", int'(bus_a.frame_end), 0);
    check("reset_error", int'(bus_a.error), 0);
    repeat (5) @(negedge clk);

    // Single pixel then latch.
    send_pixel(24'hA53C0F);
    latch(0, 1);

    // Back-to-back pixels, one latch.
    send_pixel(24'hFF0000);
    send_pixel(24'h00FF00);
    send_pixel(24'h000001);
    latch(0, 1);

    // Threshold boundaries: widths 14/15 as the last two bits of 0xABCDEF -> 0xABCDED.
    expect_pixel(24'hABCDED);
    send_bits(24'hABCDEF, 23, 2);
    pulse(14, 17);
    pulse(15, 16);
    // Width 4 (shortest legal, a zero) and 49 (longest legal, a one) lead 0x5A5A5A.
    expect_pixel(24'h5A5A5A);
    pulse(4, 27);
    pulse(49, 11);
    send_bits(24'h5A5A5A, 21, 0);
    latch(0, 1);

    // Runt pulse of 3 cycles: error, trailing edges ignored, no pixel.
    send_bits(24'hFFFFFF, 23, 19);
    pulse(3, 20);
    check("error_after_runt", int'(bus_a.error), 1);
    send_bits(24'hFFFFFF, 23, 21);
    latch(1, 0);

    // Over-long pulse of 50 cycles.
    pulse(50, 20);
    check("error_after_long", int'(bus_a.error), 1);
    latch(1, 0);

    // Partial pixel: 12 good bits then latch.
    send_bits(24'hC3C3C3, 23, 12);
    latch(1, 0);

    // Reset mid-pixel after 10 bits, then a clean pixel.
    send_bits(24'hFFFFFF, 23, 14);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_frame = 0;
    repeat (5) @(negedge clk);
    send_pixel(24'h123456);
    check("error_after_reset_pixel", int'(bus_a.error), 0);
    latch(0, 1);

    // Four pixels: dut_b count saturates at 2.
    send_pixel(24'h010203);
    send_pixel(24'h808080);
    send_pixel(24'h7E7E7E);
    send_pixel(24'hFEDCBA);
    latch(0, 1);

    repeat (10) @(negedge clk);
    check("pixels_outstanding_a", qa.size(), 0);
    check("pixels_outstanding_b", qb.size(), 0);
    check("frame_ends_outstanding", qf.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
